dehaze_window_gen: RTL and testbench
====================================

Name: dehaze_window_gen

Overview:
Streaming 3x3 window generator that feeds the dehaze pipeline (ALE and downstream transmission/recovery blocks). Accepts one raster-order RGB pixel per valid cycle and emits one 3x3 neighbourhood per image pixel, including the borders. Uses two line buffers and a 3x3 register array. After the last input pixel it self-flushes the final rows.

Parameters:
IMG_WIDTH, 512, pixels per line (>=4)
IMG_HEIGHT, 512, lines per frame (>=3)
PIX_W, 24, pixel width, {R[23:16],G[15:8],B[7:0]}

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  in_pixel valid; no backpressure
in_pixel  in  PIX_W  raster-order input pixel
out_valid  out  1  window valid
out_pixel_1..out_pixel_9  out  PIX_W each  window, row-major; 1 = top-left, 5 = centre, 9 = bottom-right
frame_done  out  1  one-cycle pulse, coincident with the last window of a frame
overrun  out  1  sticky flag; in_valid was seen during FLUSH

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Line-buffer contents are don't-care because they are masked.
- Datapath: 2*IMG_WIDTH+3-tap delay line. Consists of two IMG_WIDTH line buffers plus 3-wide shift registers on each row. Advances only on accepted input, or on each FLUSH cycle.
- Window k: window with raster centre index k is registered and emitted with out_valid=1 one cycle after input index k+IMG_WIDTH+1 is accepted. Windows with k > N-IMG_WIDTH-2 (N = IMG_WIDTH*IMG_HEIGHT) are instead emitted during FLUSH.
- Border masking, based on centre row/col counters, not stream position:
  - col==0: left column padded
  - col==IMG_WIDTH-1: right column padded
  - row==0: top row padded
  - row==IMG_HEIGHT-1: bottom row padded
  - Corners apply both masks.
  - Default pad value is 0.
- State machine:
  - IDLE -> FILL on first accepted pixel.
  - FILL -> RUN once IMG_WIDTH+1 pixels have been accepted; the first window is emitted after the (IMG_WIDTH+2)th pixel.
  - RUN -> FLUSH after input index N-1 is accepted.
  - FLUSH emits exactly IMG_WIDTH+1 windows on consecutive cycles, without waiting for input.
  - FLUSH -> IDLE after the last window; frame_done is asserted with that window.
- Input gaps: in_valid=0 in FILL/RUN stalls the pipe; no output that cycle and out_valid deasserts.
- in_valid during FLUSH: pixel dropped, overrun set. overrun clears only on rst.
- Back-to-back frames: a pixel arriving in the cycle right after frame_done is accepted as index 0 of the next frame (IDLE accepts).
- Counters: in_col/in_row wrap at IMG_WIDTH/IMG_HEIGHT; centre counters track the emitted window. Widths are $clog2 of the bounds.
- Reset mid-frame: rst asynchronously returns to IDLE. No partial windows or frame_done after release; the next pixel is index 0.
- Total windows per frame: exactly N.

Optional Feature:
BORDER_REPLICATE_EN
- Defined: padded taps take the nearest in-image pixel (edge replication); corners take the centre pixel.
- Undefined: padded taps are 0.
- Latency, counts and timing are identical in both cases.

Decomposition:
- Shared package dehaze_pkg:
  - PIX_W
  - IMG_WIDTH/IMG_HEIGHT defaults
  - Window tap index constants (TAP_TL..TAP_BR)
  - State enum (IDLE, FILL, RUN, FLUSH)
- Sub-module dehaze_line_buffer:
  - IMG_WIDTH-deep, PIX_W-wide delay with shift enable.
  - Instantiated twice.
  - Implemented as BRAM with read-before-write, with registered address.

Test Plan:
Bench uses IMG_WIDTH=4, IMG_HEIGHT=4, in_pixel={k,k,k} for raster index k, and continuous in_valid.
1. Interior: window centre 5 is emitted one cycle after pixel 10 is accepted -> taps 0,1,2,4,5,6,8,9,10.
2. Corner, zero pad: first window (centre 0) appears after pixel 5 -> taps 0,0,0,0,0,1,0,4,5. Centre 3 -> 0,0,0,2,3,0,6,7,0.
3. Flush: after pixel 15, 5 windows are emitted on consecutive cycles with in_valid=0. The last (centre 15) is 10,11,0,14,15,0,0,0,0 with frame_done=1. 16 out_valid pulses in total.
4. Gaps: in_valid toggled 1/0 -> identical window sequence, with out_valid only in cycles following accepted pixels. Then in_valid during FLUSH -> overrun=1, window count still 16.
5. Reset mid-frame: rst after pixel 9 then a full frame -> no stray outputs, new frame matches scenario 1-3 values, and exactly one frame_done.
6. With BORDER_REPLICATE_EN: centre 0 -> 0,0,1,0,0,1,4,4,5. Centre 15 -> 10,11,11,14,15,15,14,15,15.

Source files
------------

// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehaze 3x3 window generator.
//   - default pixel width and image geometry
//   - window tap indices, row-major (TAP_TL = top-left ... TAP_BR = bottom-right)
//   - window generator state encoding
package dehaze_pkg;

  localparam int PIX_W_DEF      = 24;   // {R[23:16], G[15:8], B[7:0]}
  localparam int IMG_WIDTH_DEF  = 512;
  localparam int IMG_HEIGHT_DEF = 512;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/dehaze_line_buffer.sv
// DEPTH-deep, PIX_W-wide delay line, advancing only when shift_en is high.
// Memory-style buffer: the address register points at the oldest entry,
// which is read (dout) and overwritten by din in the same shift, so dout is
// always din delayed by exactly DEPTH shifts. Contents are not reset.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (address pointer only)
//   shift_en  - advance the delay line by one
//   din       - value written on shift
//   dout      - value written DEPTH shifts ago
module dehaze_line_buffer #(
  parameter int DEPTH = 512,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (shift_en) addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  // Read-before-write: dout shows the old entry during the shifting cycle.
  always_ff @(posedge clk) begin
    if (shift_en) mem[addr_q] <= din;
  end

  assign dout = mem[addr_q];

endmodule

// File: rtl/dehaze_window_gen.sv
// Streaming 3x3 window generator for the dehaze pipeline.
// Takes one raster-order pixel per in_valid cycle and emits one registered
// 3x3 neighbourhood per image pixel (borders included), one cycle after the
// pixel that completes it. After the last pixel of a frame it flushes the
// final IMG_WIDTH+1 windows on its own.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   in_valid, in_pixel         - input pixel stream, no backpressure
//   out_valid                  - window valid
//   out_pixel_1..out_pixel_9   - window, row-major, 5 = centre
//   frame_done                 - pulse with the last window of a frame
//   overrun                    - sticky: input arrived while flushing (dropped)
// Build option: define BORDER_REPLICATE_EN to pad borders by edge
// replication instead of zeros.
module dehaze_window_gen
  import dehaze_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel_1,
  output logic [PIX_W-1:0] out_pixel_2,
  output logic [PIX_W-1:0] out_pixel_3,
  output logic [PIX_W-1:0] out_pixel_4,
  output logic [PIX_W-1:0] out_pixel_5,
  output logic [PIX_W-1:0] out_pixel_6,
  output logic [PIX_W-1:0] out_pixel_7,
  output logic [PIX_W-1:0] out_pixel_8,
  output logic [PIX_W-1:0] out_pixel_9,
  output logic             frame_done,
  output logic             overrun
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

  // [row][col]; row 0 = top, col 0 = left (oldest sample of that row)
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  state_e                state_q, state_d;
  logic [CW-1:0]         in_col_q, in_col_d;
  logic [RW-1:0]         in_row_q, in_row_d;
  logic [CW-1:0]         cen_col_q, cen_col_d;
  logic [RW-1:0]         cen_row_q, cen_row_d;
  logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic [8:0][PIX_W-1:0] out_q, out_d;
  win_t                  win_q, win_d, win_m;

  logic                  accept, advance, emit;
  logic [PIX_W-1:0]      pix_in, lb0_dout, lb1_dout;

  assign accept  = in_valid && (state_q != ST_FLUSH);
  assign advance = accept || (state_q == ST_FLUSH);
  assign emit    = (accept && (state_q == ST_RUN)) || (state_q == ST_FLUSH);
  // Flush pushes zeros; those taps always land in a masked position.
  assign pix_in  = (state_q == ST_FLUSH) ? '0 : in_pixel;

  // lb0 delays the stream by one line (middle row), lb1 by two (top row).
  dehaze_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb0 (
    .clk(clk), .rst(rst), .shift_en(advance), .din(pix_in),   .dout(lb0_dout)
  );
  dehaze_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
    .clk(clk), .rst(rst), .shift_en(advance), .din(lb0_dout), .dout(lb1_dout)
  );

  // Row shift registers: newest sample enters on the right.
  always_comb begin
    win_d = win_q;
    if (advance) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_dout;
      win_d[1][2] = lb0_dout;
      win_d[2][2] = pix_in;
    end
  end

  // Border masking from the centre counters. Columns first, then rows, so
  // with replication a corner tap picks up the centre pixel.
  always_comb begin
    win_m = win_d;
    for (int r = 0; r < 3; r++) begin
`ifdef BORDER_REPLICATE_EN
      if (cen_col_q == '0)      win_m[r][0] = win_d[r][1];
      if (cen_col_q == COL_LAST) win_m[r][2] = win_d[r][1];
`else
      if (cen_col_q == '0)      win_m[r][0] = '0;
      if (cen_col_q == COL_LAST) win_m[r][2] = '0;
`endif
    end
`ifdef BORDER_REPLICATE_EN
    if (cen_row_q == '0)      win_m[0] = win_m[1];
    if (cen_row_q == ROW_LAST) win_m[2] = win_m[1];
`else
    if (cen_row_q == '0)      win_m[0] = '0;
    if (cen_row_q == ROW_LAST) win_m[2] = '0;
`endif
  end

  always_comb begin
    out_d = out_q;
    if (emit) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          out_d[r*3 + c] = win_m[r][c];
    end
  end

  always_comb begin
    state_d      = state_q;
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    cen_col_d    = cen_col_q;
    cen_row_d    = cen_row_q;
    flush_cnt_d  = flush_cnt_q;
    out_valid_d  = emit;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (in_valid && (state_q == ST_FLUSH));

    if (accept) begin
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end

    if (emit) begin
      if (cen_col_q == COL_LAST) begin
        cen_col_d = '0;
        cen_row_d = (cen_row_q == ROW_LAST) ? '0 : cen_row_q + RW'(1);
      end else begin
        cen_col_d = cen_col_q + CW'(1);
      end
    end

    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FILL;
      // Pixel at row 1 col 0 is the (IMG_WIDTH+1)th: window 0 needs one more.
      ST_FILL:  if (accept && (in_row_q == RW'(1)) && (in_col_q == '0)) state_d = ST_RUN;
      ST_RUN: begin
        if (accept && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST)) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_col_q     <= '0;
      in_row_q     <= '0;
      cen_col_q    <= '0;
      cen_row_q    <= '0;
      flush_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      cen_col_q    <= cen_col_d;
      cen_row_q    <= cen_row_d;
      flush_cnt_q  <= flush_cnt_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      out_q        <= out_d;
    end
  end

  // Tap registers need no reset: stale taps are always masked.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign out_pixel_1 = out_q[TAP_TL];
  assign out_pixel_2 = out_q[TAP_TC];
  assign out_pixel_3 = out_q[TAP_TR];
  assign out_pixel_4 = out_q[TAP_ML];
  assign out_pixel_5 = out_q[TAP_MC];
  assign out_pixel_6 = out_q[TAP_MR];
  assign out_pixel_7 = out_q[TAP_BL];
  assign out_pixel_8 = out_q[TAP_BC];
  assign out_pixel_9 = out_q[TAP_BR];

endmodule

// File: tb/tb_dehaze_window_gen.sv
// Directed bench for dehaze_window_gen on a 4x4 image, pixel k = {k,k,k}.
// Expected windows come from image geometry (neighbour of the centre, padded
// outside the image) plus hand-written vectors for selected centres.
module tb_dehaze_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int PW = 24;
  localparam int LW = 9 * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          out_valid, frame_done, overrun;
  logic [PW-1:0] op1, op2, op3, op4, op5, op6, op7, op8, op9;

  dehaze_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_valid(out_valid),
    .out_pixel_1(op1), .out_pixel_2(op2), .out_pixel_3(op3),
    .out_pixel_4(op4), .out_pixel_5(op5), .out_pixel_6(op6),
    .out_pixel_7(op7), .out_pixel_8(op8), .out_pixel_9(op9),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          nchk = 0, nerr = 0, cyc = 0;
  logic [LW-1:0] wlog [64];
  int          wcyc [64];
  bit          wfd  [64];
  int          nwin = 0, nfd = 0;
  int          acc  [N];

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, b, b};
  endfunction

  function automatic logic [LW-1:0] hv(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {pix(a0), pix(a1), pix(a2), pix(a3), pix(a4), pix(a5), pix(a6), pix(a7), pix(a8)};
  endfunction

  function automatic logic [LW-1:0] exp_win(input int k);
    logic [LW-1:0] w;
    logic [PW-1:0] v;
    int r, c;
    w = '0;
    for (int t = 0; t < 9; t++) begin
      r = k / W + t / 3 - 1;
      c = k % W + t % 3 - 1;
`ifdef BORDER_REPLICATE_EN
      if (r < 0) r = 0;
      if (r >= H) r = H - 1;
      if (c < 0) c = 0;
      if (c >= W) c = W - 1;
      v = pix(r * W + c);
`else
      v = (r < 0 || r >= H || c < 0 || c >= W) ? '0 : pix(r * W + c);
`endif
      w[(8 - t) * PW +: PW] = v;
    end
    return w;
  endfunction

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      if (nwin < 64) begin
        wlog[nwin] = {op1, op2, op3, op4, op5, op6, op7, op8, op9};
        wcyc[nwin] = cyc;
        wfd[nwin]  = frame_done;
      end
      nwin++;
    end
    if (frame_done === 1'b1) nfd++;
  endtask

  // Drive one frame starting in the current cycle, wait for frame_done, check.
  task automatic run_frame(input string nm, input bit gap, input bit poke, input bit exp_ovr);
    bit got_fd;
    int ecyc;
    got_fd = 1'b0;
    nwin = 0;
    nfd  = 0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_pixel = pix(k);
      acc[k]   = cyc;
      tick();
      if (gap && k < N - 1) begin
        in_valid = 1'b0;
        in_pixel = '1;
        tick();
      end
    end
    in_valid = 1'b0;
    in_pixel = '0;
    for (int i = 0; i < 40 && !got_fd; i++) begin
      if (poke && i == 1) begin
        in_valid = 1'b1;
        in_pixel = 24'hABCDEF;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      got_fd = (frame_done === 1'b1);
    end
    in_valid = 1'b0;

    chk({nm, "_frame_done_seen"}, LW'(got_fd), LW'(1));
    chk({nm, "_win_count"}, LW'(nwin), LW'(N));
    chk({nm, "_frame_done_count"}, LW'(nfd), LW'(1));
    chk({nm, "_overrun"}, LW'(overrun), LW'(exp_ovr));
    for (int k = 0; k < N && k < nwin; k++) begin
      ecyc = (k <= N - W - 2) ? acc[k + W + 1] + 1 : acc[N - 1] + 1 + (k - (N - W - 2));
      chk($sformatf("%s_win%0d", nm, k), wlog[k], exp_win(k));
      chk($sformatf("%s_cyc%0d", nm, k), LW'(wcyc[k]), LW'(ecyc));
      chk($sformatf("%s_fd%0d", nm, k), LW'(wfd[k]), LW'(k == N - 1));
    end
    if (nwin >= N) begin
      chk({nm, "_hand_c5"}, wlog[5], hv(0, 1, 2, 4, 5, 6, 8, 9, 10));
`ifdef BORDER_REPLICATE_EN
      chk({nm, "_hand_c0"},  wlog[0],  hv(0, 0, 1, 0, 0, 1, 4, 4, 5));
      chk({nm, "_hand_c15"}, wlog[15], hv(10, 11, 11, 14, 15, 15, 14, 15, 15));
`else
      chk({nm, "_hand_c0"},  wlog[0],  hv(0, 0, 0, 0, 0, 1, 0, 4, 5));
      chk({nm, "_hand_c3"},  wlog[3],  hv(0, 0, 0, 2, 3, 0, 6, 7, 0));
      chk({nm, "_hand_c15"}, wlog[15], hv(10, 11, 0, 14, 15, 0, 0, 0, 0));
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid",  LW'(out_valid),  LW'(0));
    chk("rst_frame_done", LW'(frame_done), LW'(0));
    chk("rst_overrun",    LW'(overrun),    LW'(0));
    chk("rst_window", {op1, op2, op3, op4, op5, op6, op7, op8, op9}, LW'(0));
    rst = 1'b0;
    tick();

    // Continuous frame, then a gapped frame starting in the frame_done cycle
    // with an input pulse during flush.
    run_frame("contig", 1'b0, 1'b0, 1'b0);
    run_frame("gapped", 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a frame, right after pixel 9.
    nwin = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_pixel = pix(k);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_busy", LW'(out_valid), LW'(1));
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", LW'(out_valid), LW'(0));
    chk("midrst_overrun",   LW'(overrun),   LW'(0));
    tick();
    tick();
    rst  = 1'b0;
    nwin = 0;
    nfd  = 0;
    repeat (3) tick();
    chk("midrst_quiet_win", LW'(nwin), LW'(0));
    chk("midrst_quiet_fd",  LW'(nfd),  LW'(0));
    run_frame("after_rst", 1'b0, 1'b0, 1'b0);

    nwin = 0;
    nfd  = 0;
    repeat (8) tick();
    chk("tail_quiet_win", LW'(nwin), LW'(0));
    chk("tail_quiet_fd",  LW'(nfd),  LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
